// File: rtl/bus_responder_pkg.sv
// rtl/bus_responder_pkg.sv - shared decode constants, FSM state and register bit positions
package bus_responder_pkg;

    // RAM occupies the lower half of the address space and is mirrored inside it.
    localparam logic [15:0] RAM_TOP = 16'h7FFF;

    // Register offsets inside the I/O page (AB[2:0]).
    localparam logic [2:0] IO_RELOAD_LO = 3'd0;
    localparam logic [2:0] IO_RELOAD_HI = 3'd1;
    localparam logic [2:0] IO_CTRL      = 3'd2;
    localparam logic [2:0] IO_STATUS    = 3'd3;
    localparam logic [2:0] IO_COUNT_LO  = 3'd4;
    localparam logic [2:0] IO_COUNT_HI  = 3'd5;

    // CTRL / STATUS bit positions.
    localparam int CTRL_RUN       = 0;
    localparam int CTRL_IRQ_EN    = 1;
    localparam int STATUS_PENDING = 0;

    typedef enum logic {
        IDLE,
        WAIT
    } ext_state_t;

endpackage

// File: rtl/bus_timer.sv
// rtl/bus_timer.sv - IRQ down-counter timer living in the I/O register page
//
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   wr_en       register write strobe (sampled core write to the register window)
//   rd_en       register read strobe (sampled core read to the register window)
//   offset      register offset AB[2:0]
//   wdata       write data
//   rdata       combinational read data for offset
//   irq         pending & irq_en
module bus_timer
    import bus_responder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic [2:0] offset,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       irq
);

    logic [15:0] reload;
    logic [15:0] count;
    logic [1:0]  ctrl;
    logic        pending;
    logic [7:0]  count_hi_snap;

    logic run;
    logic ctrl_wr;
    logic run_start;
    logic expire;
    logic status_clr;

    assign run        = ctrl[CTRL_RUN];
    assign ctrl_wr    = wr_en && (offset == IO_CTRL);
    assign run_start  = ctrl_wr && wdata[CTRL_RUN] && !run;
    assign expire     = run && (count == 16'h0000);
    assign status_clr = wr_en && (offset == IO_STATUS) && wdata[STATUS_PENDING];

    always_ff @(posedge clk) begin
        if (reset) begin
            reload        <= 16'h0000;
            count         <= 16'h0000;
            ctrl          <= 2'b00;
            pending       <= 1'b0;
            count_hi_snap <= 8'h00;
        end else begin
            if (wr_en && (offset == IO_RELOAD_LO)) reload[7:0]  <= wdata;
            if (wr_en && (offset == IO_RELOAD_HI)) reload[15:8] <= wdata;
            if (ctrl_wr) begin
                ctrl[CTRL_RUN]    <= wdata[CTRL_RUN];
                ctrl[CTRL_IRQ_EN] <= wdata[CTRL_IRQ_EN];
            end

            if (run_start) begin
                count <= reload;
            end else if (run) begin
                count <= expire ? reload : count - 16'd1;
            end

            // Expiry has priority over a software clear landing on the same edge.
            if (expire) begin
                pending <= 1'b1;
            end else if (status_clr) begin
                pending <= 1'b0;
            end

            // Reading the low byte freezes the high byte so a 16-bit read is coherent.
            if (rd_en && (offset == IO_COUNT_LO)) count_hi_snap <= count[15:8];
        end
    end

    always_comb begin
        rdata = 8'h00;
        case (offset)
            IO_RELOAD_LO: rdata = reload[7:0];
            IO_RELOAD_HI: rdata = reload[15:8];
            IO_CTRL:      rdata[1:0] = ctrl;
            IO_STATUS:    rdata[STATUS_PENDING] = pending;
            IO_COUNT_LO:  rdata = count[7:0];
            IO_COUNT_HI:  rdata = count_hi_snap;
            default:      rdata = 8'h00;
        endcase
    end

    assign irq = pending && ctrl[CTRL_IRQ_EN];

endmodule

// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - 65C02 bus responder: RAM, timer I/O page, external req/ack window
//
// Optional feature macro: BUS_RESPONDER_TIMEOUT_EN (external access timeout + bus_err).
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   AB, DO, WE           core address / write data / write enable, sampled when rdy=1
//   DB                   read data for the access sampled on the previous rdy=1 edge
//   rdy                  core clock enable; low while an external access is pending
//   irq                  timer interrupt to the core
//   ext_req/ext_we       external request (held until ext_ack) and direction
//   ext_addr/ext_wdata   external address / write data, stable while ext_req=1
//   ext_ack/ext_rdata    one-cycle completion strobe and read data
//   bus_err              one-cycle pulse on external timeout
module bus_responder
    import bus_responder_pkg::*;
#(
    parameter int         RAM_AW      = 12,
    parameter logic [7:0] IO_PAGE     = 8'hBF,
    parameter logic [7:0] EXT_BASE    = 8'hC0,
    parameter int         EXT_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] AB,
    input  logic [7:0]  DO,
    input  logic        WE,
    output logic [7:0]  DB,
    output logic        rdy,
    output logic        irq,
    output logic        ext_req,
    output logic        ext_we,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic        ext_ack,
    input  logic [7:0]  ext_rdata,
    output logic        bus_err
);

    ext_state_t state, state_next;

    logic [7:0] ram [0:(1 << RAM_AW) - 1];

    logic       ram_hit;
    logic       io_hit;
    logic       ext_hit;
    logic       timeout;
    logic [7:0] timer_rdata;
    logic [7:0] local_rdata;

    // The core only advances (and its bus outputs only mean anything) while idle.
    assign rdy = (state == IDLE);

    assign ram_hit = (AB <= RAM_TOP);
    assign io_hit  = (AB[15:8] == IO_PAGE) && (AB[7:3] == 5'd0);
    assign ext_hit = (AB[15:8] >= EXT_BASE);

    bus_timer u_timer (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (rdy && io_hit && WE),
        .rd_en  (rdy && io_hit && !WE),
        .offset (AB[2:0]),
        .wdata  (DO),
        .rdata  (timer_rdata),
        .irq    (irq)
    );

    always_ff @(posedge clk) begin
        if (rdy && ram_hit && WE) ram[AB[RAM_AW-1:0]] <= DO;
    end

    always_comb begin
        local_rdata = 8'hFF;
        if (ram_hit) begin
            local_rdata = ram[AB[RAM_AW-1:0]];
        end else if (io_hit) begin
            local_rdata = timer_rdata;
        end
    end

`ifdef BUS_RESPONDER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(EXT_TIMEOUT - 1);

    logic [15:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (reset || rdy) begin
            wait_cnt <= 16'd0;
        end else begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    // An ack arriving on the final wait cycle still wins over the abort.
    assign timeout = !rdy && !ext_ack && (wait_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_err <= 1'b0;
        end else begin
            bus_err <= timeout;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = EXT_TIMEOUT[0];
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ext_hit) state_next = WAIT;
            WAIT:    if (ext_ack || timeout) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            DB        <= 8'h00;
            ext_req   <= 1'b0;
            ext_we    <= 1'b0;
            ext_addr  <= 16'h0000;
            ext_wdata <= 8'h00;
        end else if (rdy) begin
            if (ext_hit) begin
                ext_req   <= 1'b1;
                ext_we    <= WE;
                ext_addr  <= AB;
                ext_wdata <= DO;
            end else if (!WE) begin
                DB <= local_rdata;
            end
        end else if (ext_ack) begin
            ext_req <= 1'b0;
            if (!ext_we) DB <= ext_rdata;
        end else if (timeout) begin
            ext_req <= 1'b0;
            if (!ext_we) DB <= 8'hFF;
        end
    end

endmodule

// File: tb/tb_bus_responder.sv
// tb/tb_bus_responder.sv - self-checking bench for bus_responder
module tb_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] AB;
    logic [7:0]  DO;
    logic        WE;
    logic [7:0]  DB;
    logic        rdy;
    logic        irq;
    logic        ext_req;
    logic        ext_we;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic        ext_ack;
    logic [7:0]  ext_rdata;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:4095];

    bus_responder dut (
        .clk       (clk),
        .reset     (reset),
        .AB        (AB),
        .DO        (DO),
        .WE        (WE),
        .DB        (DB),
        .rdy       (rdy),
        .irq       (irq),
        .ext_req   (ext_req),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_ack   (ext_ack),
        .ext_rdata (ext_rdata),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One core bus cycle: present the access, let the edge sample it, observe 1 ns later.
    task automatic cycle(input logic [15:0] a, input logic [7:0] d, input logic w);
        AB = a; DO = d; WE = w;
        @(posedge clk); #1;
        if (w && a <= 16'h7FFF) mem[a[11:0]] = d;
    endtask

    task automatic test_reset();
        reset = 1'b1; AB = 16'h9000; DO = 8'h00; WE = 1'b0; ext_ack = 1'b0; ext_rdata = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checks++; if (DB !== 8'h00) begin errors++; $display("FAIL reset_db: got %h want 00", DB); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", rdy); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
        checks++; if (ext_req !== 1'b0) begin errors++; $display("FAIL reset_ext_req: got %b want 0", ext_req); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
    endtask

    task automatic test_ram();
        logic [15:0] addrs [16];
        logic [15:0] a;
        cycle(16'h0123, 8'h5A, 1'b1);
        cycle(16'h0123, 8'h00, 1'b0);
        checks++; if (DB !== 8'h5A || rdy !== 1'b1) begin errors++; $display("FAIL ram_direct: got DB=%h rdy=%b want 5a 1", DB, rdy); end
        cycle(16'h1123, 8'h00, 1'b0);
        checks++; if (DB !== 8'h5A) begin errors++; $display("FAIL ram_mirror: got %h want 5a", DB); end
        for (int i = 0; i < 16; i++) begin
            addrs[i] = 16'($urandom_range(0, 16'h7FFF));
            cycle(addrs[i], 8'($urandom), 1'b1);
        end
        for (int i = 0; i < 16; i++) begin
            a = {1'b0, 3'($urandom), addrs[i][11:0]};
            cycle(a, 8'h00, 1'b0);
            checks++; if (DB !== mem[a[11:0]]) begin errors++; $display("FAIL ram_random %h: got %h want %h", a, DB, mem[a[11:0]]); end
        end
    endtask

    task automatic test_unmapped();
        cycle(16'h9000, 8'h00, 1'b0);
        checks++; if (DB !== 8'hFF) begin errors++; $display("FAIL unmapped_read: got %h want ff", DB); end
        cycle(16'hBF10, 8'h00, 1'b0);
        checks++; if (DB !== 8'hFF) begin errors++; $display("FAIL io_hole_read: got %h want ff", DB); end
        cycle(16'h1000, 8'h77, 1'b1);
        cycle(16'h9000, 8'hAA, 1'b1);
        cycle(16'h1000, 8'h00, 1'b0);
        checks++; if (DB !== 8'h77) begin errors++; $display("FAIL unmapped_write_dropped: got %h want 77", DB); end
    endtask

    task automatic ext_access(input logic [15:0] a, input logic [7:0] d, input logic w, input int lat);
        logic [7:0] rd;
        int stalls;
        rd = 8'($urandom);
        stalls = 0;
        cycle(a, d, w);
        checks++;
        if (ext_req !== 1'b1 || ext_addr !== a || ext_we !== w || (w && ext_wdata !== d)) begin
            errors++;
            $display("FAIL ext_issue: got req=%b addr=%h we=%b wdata=%h want 1 %h %b %h", ext_req, ext_addr, ext_we, ext_wdata, a, w, d);
        end
        // Bus garbage while stalled must not be acted on.
        AB = 16'h0000; DO = 8'hEE; WE = 1'b1;
        for (int i = 1; i <= lat; i++) begin
            if (rdy === 1'b0) stalls++;
            checks++; if (ext_addr !== a) begin errors++; $display("FAIL ext_addr_hold: got %h want %h", ext_addr, a); end
            if (i == lat) begin
                ext_ack = 1'b1; ext_rdata = rd; AB = 16'h9000; WE = 1'b0;
            end
            @(posedge clk); #1;
        end
        ext_ack = 1'b0;
        checks++; if (stalls != lat) begin errors++; $display("FAIL ext_stall_count: got %0d want %0d", stalls, lat); end
        checks++; if (rdy !== 1'b1 || ext_req !== 1'b0) begin errors++; $display("FAIL ext_release: got rdy=%b req=%b want 1 0", rdy, ext_req); end
        if (!w) begin
            checks++; if (DB !== rd) begin errors++; $display("FAIL ext_rdata: got %h want %h", DB, rd); end
        end
    endtask

    task automatic test_ext();
        cycle(16'h0000, 8'h42, 1'b1);
        ext_access(16'hC000, 8'h00, 1'b0, 3);
        for (int i = 0; i < 6; i++) begin
            ext_access(16'($urandom_range(16'hC000, 16'hFFFF)), 8'($urandom), 1'(i % 2), $urandom_range(1, 6));
        end
        cycle(16'h0000, 8'h00, 1'b0);
        checks++; if (DB !== mem[0]) begin errors++; $display("FAIL stall_inputs_ignored: got %h want %h", DB, mem[0]); end
        // An ack while idle must not disturb anything.
        ext_ack = 1'b1; ext_rdata = 8'h99;
        cycle(16'h0123, 8'h00, 1'b0);
        ext_ack = 1'b0;
        checks++; if (DB !== mem[12'h123] || ext_req !== 1'b0 || rdy !== 1'b1) begin
            errors++; $display("FAIL stray_ack: got DB=%h req=%b rdy=%b want %h 0 1", DB, ext_req, rdy, mem[12'h123]);
        end
    endtask

    // Pending is set on every P-th edge after the run start (P = RELOAD + 1) and
    // cleared by a STATUS write that does not coincide with a set.
    task automatic test_timer();
        logic pend;
        logic clr;
        int r;
        int p;
        for (int run = 0; run < 5; run++) begin
            r = (run == 0) ? 4 : (run == 1) ? 0 : $urandom_range(1, 6);
            p = r + 1;
            cycle(16'hBF02, 8'h00, 1'b1);
            cycle(16'hBF03, 8'h01, 1'b1);
            cycle(16'hBF00, 8'(r), 1'b1);
            cycle(16'hBF01, 8'h00, 1'b1);
            cycle(16'hBF02, 8'h03, 1'b1);
            pend = 1'b0;
            for (int e = 1; e <= 3 * p + 2; e++) begin
                if (run == 0) clr = (e == 6);
                else clr = (e == p) || ($urandom_range(0, 3) == 0);
                if (clr) begin AB = 16'hBF03; DO = 8'h01; WE = 1'b1; end
                else begin AB = 16'h9000; WE = 1'b0; end
                @(posedge clk); #1;
                if (e % p == 0) pend = 1'b1;
                else if (clr) pend = 1'b0;
                checks++; if (irq !== pend) begin errors++; $display("FAIL timer_irq reload=%0d edge=%0d: got %b want %b", r, e, irq, pend); end
            end
        end
        // Counter snapshot: reload 0x0201, low byte read when count=0x0200.
        cycle(16'hBF02, 8'h00, 1'b1);
        cycle(16'hBF03, 8'h01, 1'b1);
        cycle(16'hBF00, 8'h01, 1'b1);
        cycle(16'hBF01, 8'h02, 1'b1);
        cycle(16'hBF02, 8'h01, 1'b1);
        cycle(16'h9000, 8'h00, 1'b0);
        cycle(16'hBF04, 8'h00, 1'b0);
        checks++; if (DB !== 8'h00) begin errors++; $display("FAIL count_lo: got %h want 00", DB); end
        cycle(16'hBF05, 8'h00, 1'b0);
        checks++; if (DB !== 8'h02) begin errors++; $display("FAIL count_hi_snapshot: got %h want 02", DB); end
        cycle(16'hBF00, 8'h00, 1'b0);
        checks++; if (DB !== 8'h01) begin errors++; $display("FAIL reload_lo_read: got %h want 01", DB); end
        cycle(16'hBF06, 8'h00, 1'b0);
        checks++; if (DB !== 8'h00) begin errors++; $display("FAIL io_reserved_read: got %h want 00", DB); end
        cycle(16'hBF02, 8'h00, 1'b1);
    endtask

`ifdef BUS_RESPONDER_TIMEOUT_EN
    task automatic test_timeout();
        int stalls;
        stalls = 0;
        cycle(16'hC123, 8'h00, 1'b0);
        AB = 16'h9000; WE = 1'b0;
        while (rdy === 1'b0 && stalls < 40) begin
            stalls++;
            checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL bus_err_early: got %b want 0 at stall %0d", bus_err, stalls); end
            @(posedge clk); #1;
        end
        checks++; if (stalls != 16) begin errors++; $display("FAIL timeout_stalls: got %0d want 16", stalls); end
        checks++; if (bus_err !== 1'b1 || DB !== 8'hFF || rdy !== 1'b1 || ext_req !== 1'b0) begin
            errors++; $display("FAIL timeout_abort: got err=%b DB=%h rdy=%b req=%b want 1 ff 1 0", bus_err, DB, rdy, ext_req);
        end
        @(posedge clk); #1;
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL bus_err_pulse: got %b want 0", bus_err); end
    endtask
`else
    task automatic test_timeout();
        cycle(16'hC123, 8'h00, 1'b0);
        AB = 16'h9000; WE = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++; if (rdy !== 1'b0 || ext_req !== 1'b1 || bus_err !== 1'b0) begin
            errors++; $display("FAIL wait_persists: got rdy=%b req=%b err=%b want 0 1 0", rdy, ext_req, bus_err);
        end
        ext_ack = 1'b1; ext_rdata = 8'h6D;
        @(posedge clk); #1;
        ext_ack = 1'b0;
        checks++; if (rdy !== 1'b1 || DB !== 8'h6D) begin errors++; $display("FAIL late_ack: got rdy=%b DB=%h want 1 6d", rdy, DB); end
    endtask
`endif

    task automatic test_reset_in_wait();
        cycle(16'hC010, 8'h00, 1'b0);
        AB = 16'h9000; WE = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (ext_req !== 1'b0 || rdy !== 1'b1 || DB !== 8'h00) begin
            errors++; $display("FAIL reset_in_wait: got req=%b rdy=%b DB=%h want 0 1 00", ext_req, rdy, DB);
        end
        // Late ack from the aborted access, alongside a RAM write (which leaves DB alone).
        ext_ack = 1'b1; ext_rdata = 8'h55;
        cycle(16'h0200, 8'h11, 1'b1);
        ext_ack = 1'b0;
        checks++; if (rdy !== 1'b1 || ext_req !== 1'b0 || DB !== 8'h00) begin
            errors++; $display("FAIL late_ack_ignored: got rdy=%b req=%b DB=%h want 1 0 00", rdy, ext_req, DB);
        end
        cycle(16'h0200, 8'h00, 1'b0);
        checks++; if (DB !== 8'h11) begin errors++; $display("FAIL post_reset_ram: got %h want 11", DB); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_unmapped();
        test_ext();
        test_timer();
        test_timeout();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
